// File: rtl/shift_deser.sv
// Shift-in receiver: packs IN_SIZE serial lanes per enabled cycle into SIZE-bit words and hands
// them out over valid/ready. Build option SHIFT_DESER_LSB_FIRST_EN selects LSB-first assembly.
module shift_deser #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned IN_SIZE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_SIZE-1:0] din,
  input  logic               se,
  input  logic               clr,
  output logic [SIZE-1:0]    dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy,
  output logic               lst_cycle,
  output logic               overrun
);

  localparam int unsigned CntW = $clog2(SIZE) + 1;
  localparam logic [CntW-1:0] SizeCnt = CntW'(SIZE);
  localparam logic [CntW-1:0] StepCnt = CntW'(IN_SIZE);

  if ((IN_SIZE == 0) || (SIZE % IN_SIZE != 0)) begin : g_bad_cfg
    $error("shift_deser: SIZE must be a non-zero multiple of IN_SIZE");
  end

  typedef enum logic {StIdle, StShift} state_e;

  logic [SIZE-1:0] sreg_q, sreg_d;
  logic [CntW-1:0] count_q, count_d;
  logic [SIZE-1:0] dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic [SIZE-1:0] sreg_shift;
  state_e          state;
  logic            accept;
  logic            out_free;

  if (IN_SIZE == SIZE) begin : g_full
    assign sreg_shift = din;
  end else begin : g_part
`ifdef SHIFT_DESER_LSB_FIRST_EN
    assign sreg_shift = {din, sreg_q[SIZE-1:IN_SIZE]};
`else
    assign sreg_shift = {sreg_q[SIZE-IN_SIZE-1:0], din};
`endif
  end

  // The count register is the state; the enum only names its two legal regions.
  assign state    = (count_q == SizeCnt) ? StIdle : StShift;
  assign accept   = valid_q & dout_ready;
  assign out_free = ~valid_q | accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      count_q   <= SizeCnt;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    sreg_d    = sreg_q;
    count_d   = count_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (accept) begin
      valid_d = 1'b0;
    end

    if (clr) begin
      // Abort drops any partial word but leaves a held output word alone.
      count_d   = SizeCnt;
      overrun_d = 1'b0;
    end else if (se) begin
      sreg_d = sreg_shift;
      if (count_q == StepCnt) begin
        count_d = SizeCnt;
        if (out_free) begin
          dout_d  = sreg_shift;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        count_d = count_q - StepCnt;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state == StShift);
  assign lst_cycle  = (count_q == StepCnt);

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: single-lane and quad-lane instances, table-driven words plus
// hand-written backpressure, back-to-back, abort, reset and gap sequences.
module tb_shift_deser;

`ifdef SHIFT_DESER_LSB_FIRST_EN
  localparam bit Lsb = 1'b1;
`else
  localparam bit Lsb = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       se, clr, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, busy, lst_cycle, overrun;

  logic [3:0] din4;
  logic       se4;
  logic [7:0] dout4;
  logic       dout_valid4, busy4, lst_cycle4, overrun4;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  shift_deser #(.SIZE(8), .IN_SIZE(1)) dut (
    .clk(clk), .rst(rst), .din(din), .se(se), .clr(clr),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .lst_cycle(lst_cycle), .overrun(overrun)
  );

  shift_deser #(.SIZE(8), .IN_SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .se(se4), .clr(1'b0),
    .dout(dout4), .dout_valid(dout_valid4), .dout_ready(1'b1),
    .busy(busy4), .lst_cycle(lst_cycle4), .overrun(overrun4)
  );

  typedef struct {
    logic [7:0] word;     // bits sent word[7] first
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] pick(input logic [7:0] msb, input logic [7:0] lsb);
    return Lsb ? lsb : msb;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must pop the next expected word.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends w MSB-of-w first; gap idle cycles precede each bit. Leaves se high after the last edge.
  task automatic shift_word(input logic [7:0] w, input logic rdy, input logic rdy_last,
                            input int gap);
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        se  = 1'b0;
        din = 1'($urandom);
        tick();
        check("gap_busy", 32'(busy), 32'(i != 7));
        check("gap_last", 32'(lst_cycle), 32'(i == 0));
      end
      se         = 1'b1;
      din        = w[i];
      dout_ready = (i == 0) ? rdy_last : rdy;
      check("busy_pre", 32'(busy), 32'(i != 7));
      check("lst_cycle", 32'(lst_cycle), 32'(i == 0));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'hC0, 8'hC0, 8'h03};
    vecs[2] = '{8'h55, 8'h55, 8'hAA};
    vecs[3] = '{8'hAA, 8'hAA, 8'h55};
    vecs[4] = '{8'h0F, 8'h0F, 8'hF0};
    vecs[5] = '{8'h96, 8'h96, 8'h69};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[7] = '{8'h00, 8'h00, 8'h00};

    rst = 1'b1; din = '0; se = 1'b0; clr = 1'b0; dout_ready = 1'b0;
    din4 = '0; se4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_lst", 32'(lst_cycle), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_lst4", 32'(lst_cycle4), 32'h0);

    // Table-driven single-lane words, consumer always ready.
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(pick(vecs[v].exp_msb, vecs[v].exp_lsb));
      shift_word(vecs[v].word, 1'b1, 1'b1, 0);
      se = 1'b0;
      check("vec_valid", 32'(dout_valid), 32'h1);
      check("vec_dout", 32'(dout), 32'(pick(vecs[v].exp_msb, vecs[v].exp_lsb)));
      check("vec_busy", 32'(busy), 32'h0);
      tick();
      check("vec_drop", 32'(dout_valid), 32'h0);
    end

    // Quad lanes: nibble 3 then C.
    se4 = 1'b1; din4 = 4'h3;
    tick();
    din4 = 4'hC;
    check("q_lst", 32'(lst_cycle4), 32'h1);
    check("q_busy", 32'(busy4), 32'h1);
    tick();
    se4 = 1'b0;
    check("q_valid", 32'(dout_valid4), 32'h1);
    check("q_dout", 32'(dout4), 32'(pick(8'h3C, 8'hC3)));
    check("q_idle", 32'(busy4), 32'h0);

    // Backpressure: second word dropped, overrun sticky past consumption.
    exp_q.push_back(pick(8'h11, 8'h88));
    shift_word(8'h11, 1'b0, 1'b0, 0);
    shift_word(8'h22, 1'b0, 1'b0, 0);
    se = 1'b0;
    check("bp_dout", 32'(dout), 32'(pick(8'h11, 8'h88)));
    check("bp_valid", 32'(dout_valid), 32'h1);
    check("bp_overrun", 32'(overrun), 32'h1);
    tick();
    check("bp_hold", 32'(dout), 32'(pick(8'h11, 8'h88)));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("bp_consumed", 32'(dout_valid), 32'h0);
    check("bp_ovr_sticky", 32'(overrun), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("bp_ovr_clr", 32'(overrun), 32'h0);

    // Back-to-back: ready pulsed only as the second word completes.
    exp_q.push_back(pick(8'h55, 8'hAA));
    exp_q.push_back(pick(8'hAA, 8'h55));
    shift_word(8'h55, 1'b0, 1'b0, 0);
    shift_word(8'hAA, 1'b0, 1'b1, 0);
    se = 1'b0; dout_ready = 1'b0;
    check("b2b_dout", 32'(dout), 32'(pick(8'hAA, 8'h55)));
    check("b2b_valid", 32'(dout_valid), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h0);
    dout_ready = 1'b1;
    tick();
    check("b2b_drain", 32'(dout_valid), 32'h0);

    // Abort: 3 bits, clr with se high, then a full word.
    for (int i = 0; i < 3; i++) begin
      se = 1'b1; din = 1'b1;
      tick();
    end
    check("ab_busy", 32'(busy), 32'h1);
    clr = 1'b1; din = 1'b1;
    tick();
    clr = 1'b0;
    check("ab_idle", 32'(busy), 32'h0);
    check("ab_lst", 32'(lst_cycle), 32'h0);
    exp_q.push_back(pick(8'h0F, 8'hF0));
    shift_word(8'h0F, 1'b1, 1'b1, 0);
    se = 1'b0;
    check("ab_dout", 32'(dout), 32'(pick(8'h0F, 8'hF0)));
    check("ab_valid", 32'(dout_valid), 32'h1);
    tick();

    // Reset mid-word with a held word and overrun set.
    shift_word(8'h11, 1'b0, 1'b0, 0);
    shift_word(8'h22, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      se = 1'b1; din = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; se = 1'b0;
    check("rr_dout", 32'(dout), 32'h0);
    check("rr_valid", 32'(dout_valid), 32'h0);
    check("rr_busy", 32'(busy), 32'h0);
    check("rr_overrun", 32'(overrun), 32'h0);
    check("rr_lst", 32'(lst_cycle), 32'h0);

    // Gaps of 5 idle cycles between bits.
    exp_q.push_back(pick(8'h96, 8'h69));
    shift_word(8'h96, 1'b1, 1'b1, 5);
    se = 1'b0;
    check("gap_dout", 32'(dout), 32'(pick(8'h96, 8'h69)));
    check("gap_valid", 32'(dout_valid), 32'h1);
    tick(); tick();

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
